// File: rtl/mips_pkg.sv
// Shared types and constants for the pipeline memory path.
// Pure declarations: no latency, no flow control.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// Counts wait cycles of a bus transaction; terminal fires combinationally on the cycle the count would reach TIMEOUT.
// Latency 0 from enable to terminal; no flow control, clear has priority over enable.
module timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and memory-stage requests; grant->bus_valid 1 cycle, bus_done->ready 1 cycle.
// Requesters are held off through stall_f/stall_m until their one-cycle ready pulse; one transaction in flight.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_done,
    output logic              bus_err
);

    arb_state_t        state, state_nxt;
    logic              last_was_i;
    logic              kill_seen;
    logic              grant_i, grant_d;
    logic              in_wait, tmo, finish;
    logic [WORD_W-1:0] ret_data;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless the previous grant was also data and a fetch is waiting.
                if (mem_req && (!if_req || last_was_i)) begin
                    state_nxt = D_WAIT;
                    grant_d   = 1'b1;
                end else if (if_req) begin
                    state_nxt = I_WAIT;
                    grant_i   = 1'b1;
                end
            end
            I_WAIT, D_WAIT: begin
                if (bus_done || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_wait  = (state != IDLE);
    assign finish   = in_wait && (bus_done || tmo);
    assign ret_data = bus_done ? bus_rdata : '0;
    assign stall_f  = if_req & ~if_ready;
    assign stall_m  = mem_req & ~mem_ready;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (grant_i || grant_d),
        .enable   (in_wait && !bus_done),
        .terminal (tmo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_was_i <= 1'b0;
            kill_seen  <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            if_rdata   <= '0;
            if_ready   <= 1'b0;
            mem_rdata  <= '0;
            mem_ready  <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (grant_i || grant_d) begin
                bus_valid <= 1'b1;
                kill_seen <= 1'b0;
            end
            if (grant_d) begin
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
            end
            if (grant_i) begin
                bus_we   <= 1'b0;
                bus_addr <= if_addr;
            end
            if (state == I_WAIT && if_kill) begin
                kill_seen <= 1'b1;
            end
            if (finish) begin
                bus_valid <= 1'b0;
                bus_we    <= 1'b0;
                if (state == I_WAIT) begin
                    // A redirect anywhere in the wait, done cycle included, discards the word.
                    if_rdata   <= ret_data;
                    if_ready   <= !(kill_seen || if_kill);
                    last_was_i <= 1'b1;
                end else begin
                    if (!bus_we) begin
                        mem_rdata <= ret_data;
                    end
                    mem_ready  <= 1'b1;
                    last_was_i <= 1'b0;
                end
            end
            if (tmo) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized requester/memory run checked against a requester-level memory model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_f, stall_m;
    logic        bus_valid, bus_we, bus_done, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int lat     = 1;
    logic [31:0] bmem [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done),
        .bus_err   (bus_err)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    // Backing memory: completes each transaction after lat extra valid cycles.
    task automatic respond(input bit never);
        bus_done  = bus_valid && !never && (vcnt == lat);
        bus_rdata = bus_done ? mem_rd(bus_addr) : 32'h0;
        if (bus_done && bus_we) bmem[bus_addr] = bus_wdata;
        if (!bus_valid || bus_done) vcnt = 0;
        else vcnt++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; if_kill = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        bus_done = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid got %b exp 0", bus_valid); end
        n_tests++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we got %b exp 0", bus_we); end
        n_tests++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
        n_tests++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata got %h exp 0", bus_wdata); end
        n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata got %h exp 0", if_rdata); end
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_rdata got %h exp 0", mem_rdata); end
        n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got %b exp 0", if_ready); end
        n_tests++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got %b exp 0", mem_ready); end
        n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        n_tests++; if ({stall_f, stall_m} !== 2'b00) begin n_fail++; $display("FAIL reset_stalls got %b exp 00", {stall_f, stall_m}); end
    endtask

    task automatic test_fetch_only();
        bmem[32'h0040_0020] = 32'h8C08_0004;
        vcnt = 0; lat = 2;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0040_0020;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            respond(1'b0);
            n_tests++;
            if (if_ready !== (c == 4)) begin n_fail++; $display("FAIL fetch_if_ready c%0d got %b exp %b", c, if_ready, c == 4); end
            n_tests++;
            if (bus_valid !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL fetch_bus_valid c%0d got %b", c, bus_valid); end
            if (c == 1) begin
                n_tests++;
                if (bus_addr !== 32'h0040_0020 || bus_we !== 1'b0) begin n_fail++; $display("FAIL fetch_bus_addr got %h we %b exp 00400020 we 0", bus_addr, bus_we); end
            end
            if (if_ready) begin
                n_tests++;
                if (if_rdata !== 32'h8C08_0004) begin n_fail++; $display("FAIL fetch_if_rdata got %h exp 8c080004", if_rdata); end
                if_req = 1'b0;
            end
            #1;
            n_tests++;
            if (stall_f !== (c <= 3)) begin n_fail++; $display("FAIL fetch_stall_f c%0d got %b exp %b", c, stall_f, c <= 3); end
        end
    endtask

    task automatic test_contention();
        int g_type[$];
        int gaps[$];
        int low_run = 0;
        bit prev_v = 1'b0;
        bit got_rd = 1'b0;
        logic [31:0] rd0 = 32'h0;
        vcnt = 0; lat = 1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0040_0024;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1001_0000;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            respond(1'b0);
            if (bus_valid && !prev_v) begin
                g_type.push_back(bus_addr[31:28] == 4'h1 ? 1 : 0);
                if (g_type.size() > 1) gaps.push_back(low_run);
            end
            low_run = bus_valid ? 0 : low_run + 1;
            prev_v  = bus_valid;
            if (mem_ready) begin
                if (!got_rd) begin rd0 = mem_rdata; got_rd = 1'b1; mem_addr = 32'h1001_0004; end
                else mem_req = 1'b0;
            end
            if (if_ready) if_req = 1'b0;
        end
        n_tests++;
        if (g_type.size() != 3) begin n_fail++; $display("FAIL contention_grant_count got %0d exp 3", g_type.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= g_type.size() || g_type[i] != ((i == 1) ? 0 : 1)) begin
                n_fail++; $display("FAIL contention_order slot %0d got %0d exp %0d (1=D 0=I)", i, (i < g_type.size()) ? g_type[i] : -1, (i == 1) ? 0 : 1);
            end
        end
        foreach (gaps[i]) begin
            n_tests++;
            if (gaps[i] != 1) begin n_fail++; $display("FAIL contention_gap %0d got %0d exp 1", i, gaps[i]); end
        end
        n_tests++;
        if (rd0 !== mem_rd(32'h1001_0000)) begin n_fail++; $display("FAIL contention_load got %h exp %h", rd0, mem_rd(32'h1001_0000)); end
    endtask

    task automatic test_write();
        logic [31:0] rd_before;
        int pulses = 0;
        int rdy_c = -1;
        rd_before = mem_rdata;
        vcnt = 0; lat = 1;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1001_0008; mem_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            respond(1'b0);
            if (bus_valid) begin
                n_tests++;
                if (bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h1001_0008) begin
                    n_fail++; $display("FAIL write_bus got we %b data %h addr %h exp 1 deadbeef 10010008", bus_we, bus_wdata, bus_addr);
                end
            end
            if (mem_ready) begin
                pulses++; rdy_c = c;
                n_tests++;
                if (mem_rdata !== rd_before) begin n_fail++; $display("FAIL write_mem_rdata got %h exp %h", mem_rdata, rd_before); end
                mem_req = 1'b0; mem_we = 1'b0;
            end
            #1;
            n_tests++;
            if (stall_m !== (c < 3)) begin n_fail++; $display("FAIL write_stall_m c%0d got %b exp %b", c, stall_m, c < 3); end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL write_pulses got %0d exp 1", pulses); end
        n_tests++; if (rdy_c != 3) begin n_fail++; $display("FAIL write_ready_cycle got %0d exp 3", rdy_c); end
        n_tests++; if (mem_rd(32'h1001_0008) !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_memory got %h exp deadbeef", mem_rd(32'h1001_0008)); end
    endtask

    task automatic test_kill();
        vcnt = 0; lat = 2;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0040_0040;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if_kill = (c == 2);
            if (c == 2) if_addr = 32'h0040_0100;
            respond(1'b0);
            n_tests++;
            if (if_ready !== (c == 8)) begin n_fail++; $display("FAIL kill_if_ready c%0d got %b exp %b", c, if_ready, c == 8); end
            if (c == 4) begin
                n_tests++;
                if (if_rdata !== mem_rd(32'h0040_0040)) begin n_fail++; $display("FAIL kill_rdata_update got %h exp %h", if_rdata, mem_rd(32'h0040_0040)); end
            end
            if (if_ready) begin
                n_tests++;
                if (if_rdata !== mem_rd(32'h0040_0100)) begin n_fail++; $display("FAIL kill_refetch got %h exp %h", if_rdata, mem_rd(32'h0040_0100)); end
                if_req = 1'b0;
            end
        end
        if_kill = 1'b0;
    endtask

    task automatic test_timeout();
        vcnt = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1001_0010;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            respond(1'b1);
            n_tests++;
            if (bus_valid !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL tmo_bus_valid c%0d got %b", c, bus_valid); end
            n_tests++;
            if (mem_ready !== (c == 5)) begin n_fail++; $display("FAIL tmo_mem_ready c%0d got %b exp %b", c, mem_ready, c == 5); end
            n_tests++;
            if (bus_err !== (c >= 5)) begin n_fail++; $display("FAIL tmo_bus_err c%0d got %b exp %b", c, bus_err, c >= 5); end
            if (mem_ready) begin
                n_tests++;
                if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_data got %h exp 0", mem_rdata); end
                mem_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1001_0020;
        bus_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            reset    = (c == 2);
            bus_done = (c == 3);
            bus_rdata = (c == 3) ? 32'hFFFF_0000 : 32'h0;
            if (c == 3) mem_req = 1'b0;
            if (c == 5) begin if_req = 1'b1; if_addr = 32'h0040_0200; end
            if (c == 1) begin
                n_tests++;
                if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_started got %b exp 1", bus_valid); end
            end
            if (c >= 3 && c <= 5) begin
                n_tests++;
                if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_bus_valid c%0d got %b exp 0", c, bus_valid); end
                n_tests++;
                if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rmid_bus_err c%0d got %b exp 0", c, bus_err); end
            end
            if (c >= 3) begin
                n_tests++;
                if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_no_ready c%0d got ready %b data %h exp 0 0", c, mem_ready, mem_rdata); end
            end
            if (c == 6) begin
                n_tests++;
                if (bus_valid !== 1'b1 || bus_addr !== 32'h0040_0200) begin n_fail++; $display("FAIL rmid_idle_grant got valid %b addr %h exp 1 00400200", bus_valid, bus_addr); end
            end
        end
        reset = 1'b0; bus_done = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_mrd = 32'h0;
        int if_age = 0, m_age = 0, max_age = 0;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (bus_valid && vcnt == 0) lat = $urandom_range(0, 3);
            respond(1'b0);
            if (if_ready) begin
                n_tests++;
                if (!if_req) begin n_fail++; $display("FAIL rand_if_spurious c%0d", c); end
                else if (if_rdata !== mem_rd(if_addr)) begin n_fail++; $display("FAIL rand_if_data c%0d got %h exp %h", c, if_rdata, mem_rd(if_addr)); end
            end
            if (mem_ready) begin
                n_tests++;
                if (!mem_req) begin n_fail++; $display("FAIL rand_mem_spurious c%0d", c); end
                else if (mem_we && mem_rd(mem_addr) !== mem_wdata) begin n_fail++; $display("FAIL rand_store c%0d got %h exp %h", c, mem_rd(mem_addr), mem_wdata); end
                if (mem_req && !mem_we) exp_mrd = mem_rd(mem_addr);
            end
            n_tests++;
            if (mem_rdata !== exp_mrd) begin n_fail++; $display("FAIL rand_mem_rdata c%0d got %h exp %h", c, mem_rdata, exp_mrd); end
            n_tests++;
            if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rand_bus_err c%0d got %b exp 0", c, bus_err); end
            if_age = (if_req && !if_ready) ? if_age + 1 : 0;
            m_age  = (mem_req && !mem_ready) ? m_age + 1 : 0;
            if (if_age > max_age) max_age = if_age;
            if (m_age > max_age) max_age = m_age;

            if_kill = 1'b0;
            if (if_ready || !if_req) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2);
            end else if ($urandom_range(0, 9) == 0) begin
                if_kill = 1'b1;
                if_addr = 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2);
            end
            if (mem_ready || !mem_req) begin
                mem_req   = ($urandom_range(0, 2) != 0);
                mem_we    = ($urandom_range(0, 1) != 0);
                mem_addr  = 32'h1001_0000 | (32'($urandom_range(0, 15)) << 2);
                mem_wdata = $urandom;
            end
            #1;
            n_tests++;
            if (stall_f !== (if_req && !if_ready) || stall_m !== (mem_req && !mem_ready)) begin
                n_fail++; $display("FAIL rand_stalls c%0d got f%b m%b", c, stall_f, stall_m);
            end
        end
        n_tests++;
        if (max_age > 40) begin n_fail++; $display("FAIL rand_starvation got %0d cycles exp <= 40", max_age); end
        if_req = 1'b0; mem_req = 1'b0; if_kill = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_done = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_write();
        test_kill();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the fetch stage (instruction reads) and the memory stage (data reads/writes) over one shared backing-memory bus. Grants one transaction at a time and holds the bus until the memory signals completion. Returns data with a one-cycle ready pulse and drives the stall requests the hazard unit combines into stallF/stallD/stallM. Sits between `fetch`/memory-stage logic and the unified memory model.

## Interface
Parameters:
- `TIMEOUT`, 255 — max cycles a bus transaction may wait for `bus_done` before abort.

Ports (reset is synchronous, active-high; one clock):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `if_req`  in  1  fetch wants instruction at `if_addr`.
- `if_addr`  in  32  fetch address (pc_f).
- `if_kill`  in  1  branch/jump redirect; discard outstanding fetch result.
- `if_rdata`  out  32  instruction word.
- `if_ready`  out  1  one-cycle pulse: `if_rdata` valid.
- `mem_req`  in  1  memory stage access request.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data.
- `mem_ready`  out  1  one-cycle pulse: data access complete.
- `stall_f`  out  1  `if_req & ~if_ready` (combinational).
- `stall_m`  out  1  `mem_req & ~mem_ready` (combinational).
- `bus_valid`  out  1  transaction active on bus.
- `bus_we`  out  1  write strobe.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_rdata`  in  32  bus read data, valid with `bus_done`.
- `bus_done`  in  1  memory completes the current transaction.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, I_WAIT, D_WAIT.
- IDLE:
  - `mem_req` and (not `if_req` or `last_was_i`=1) → D_WAIT.
  - Else `if_req` → I_WAIT.
  - Else stay.
  - Data has priority, but after each data grant one pending fetch is served before the next data grant: the `last_was_i` toggle prevents fetch starvation.
- On grant, latch address/we/wdata into `bus_*` and assert `bus_valid` for the whole wait state. Request inputs are ignored until return to IDLE.
- I_WAIT on `bus_done`:
  - Register `bus_rdata` into `if_rdata`.
  - Pulse `if_ready`, unless a kill is pending. A kill is pending if `if_kill` was seen any cycle since the grant, including the done cycle. If so, suppress the pulse; `if_rdata` is still updated.
  - Go to IDLE and set `last_was_i`=1.
- D_WAIT on `bus_done`:
  - For reads, register `bus_rdata` into `mem_rdata`.
  - Pulse `mem_ready` for reads and writes.
  - Go to IDLE and set `last_was_i`=0.
- Timeout: a wait-state counter increments each cycle `bus_done`=0. When it reaches `TIMEOUT`:
  - Abort the transaction and return 32'h0 as data, with the ready pulse as for done.
  - Set `bus_err`.
  - Clear the counter on every grant.
- `bus_done` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `last_was_i`=0, `bus_valid`=0, `bus_we`=0, `bus_addr`/`bus_wdata`=0, `if_rdata`/`mem_rdata`=0, `if_ready`/`mem_ready`=0, `bus_err`=0, counter 0.
- Request seen in IDLE at cycle 0 → `bus_valid`=1 at cycle 1.
- `bus_done` at cycle k≥1 → ready pulse and data at cycle k+1, state IDLE at k+1.
- A new grant is possible at k+1, giving `bus_valid` at k+2. `bus_valid` is low for exactly one cycle between back-to-back transactions.
- Minimum request-to-ready latency: 2 cycles.
- Ready pulses are exactly one cycle wide. Requesters hold request and operands stable until their ready.
- Reset mid-transaction: return to IDLE next edge; drop `bus_valid`; no ready pulse; a late `bus_done` is ignored.
- `if_kill` and `bus_done` in the same cycle: the result is discarded.
- `if_kill` while IDLE has no effect.

## Structure
- Shared package `mips_pkg`: state enum (IDLE/I_WAIT/D_WAIT), `WORD_W`=32, reset-PC constant.
- One natural sub-module, `timeout_counter`: load-clear, enable, terminal-count output, parameterised by `TIMEOUT`.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x00400020, `bus_done` 2 cycles after `bus_valid`, `bus_rdata`=0x8C080004. Required: `if_ready` pulses once at cycle 4, `if_rdata`=0x8C080004, `stall_f` high cycles 0–3.
- Contention: `if_req` and `mem_req` (read 0x10010000) both high in IDLE. Required: data granted first, then fetch, then the next data request; grant order D, I, D.
- Write: `mem_we`=1, `mem_wdata`=0xDEADBEEF. Required: `bus_we`=1 and `bus_wdata`=0xDEADBEEF while `bus_valid`; `mem_ready` pulses; `mem_rdata` unchanged.
- Kill: fetch granted, `if_kill` one cycle mid-wait. Required: no `if_ready` pulse; the next `if_req` is served normally.
- Timeout: `TIMEOUT`=4, `bus_done` never asserted. Required: ready pulse with data 0 after 4 wait cycles; `bus_err`=1 and stays set.
- Reset during D_WAIT, then `bus_done`. Required: no `mem_ready`; `bus_valid`=0; state IDLE.
